// File: rtl/cpu_pkg.sv
// cpu_pkg: shared ALU function codes and the byte sequencer's state encoding.
//   FN_AND/FN_OR/FN_XOR/FN_PASS : 2-bit ALU function codes
//   state_t                     : sequencer states IDLE, RUN, DONE
package cpu_pkg;

    localparam logic [1:0] FN_AND  = 2'b00;
    localparam logic [1:0] FN_OR   = 2'b01;
    localparam logic [1:0] FN_XOR  = 2'b10;
    localparam logic [1:0] FN_PASS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_byte_sequencer.sv
// alu_byte_sequencer: runs one NBYTES-wide operation through an external 8-bit ALU, LSB byte first.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake carrying req_fn, req_a, req_b
//   rsp_valid/rsp_ready   : response handshake carrying rsp_result, rsp_n, rsp_v, rsp_z
//   alu_fn/alu_a/alu_b    : byte-wide operation presented to the ALU
//   alu_sum/alu_n/alu_v/alu_z : combinational ALU result and flags for that byte
module alu_byte_sequencer
    import cpu_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_fn,
    input  logic [8*NBYTES-1:0]   req_a,
    input  logic [8*NBYTES-1:0]   req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [8*NBYTES-1:0]   rsp_result,
    output logic                  rsp_n,
    output logic                  rsp_v,
    output logic                  rsp_z,
    output logic [1:0]            alu_fn,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    input  logic [7:0]            alu_sum,
    input  logic                  alu_n,
    input  logic                  alu_v,
    input  logic                  alu_z
);

    localparam int IW = $clog2(NBYTES);
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    state_t                state, state_nx;
    logic [IW-1:0]         idx;
    logic [1:0]            fn_q;
    logic [8*NBYTES-1:0]   a_q, b_q;
    logic                  z_acc;
    logic                  last;

    assign last = (idx == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            fn_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            z_acc      <= 1'b1;
            rsp_result <= '0;
            rsp_n      <= 1'b0;
            rsp_v      <= 1'b0;
            rsp_z      <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && req_valid) begin
                fn_q  <= req_fn;
                a_q   <= req_a;
                b_q   <= req_b;
                idx   <= '0;
                z_acc <= 1'b1;
            end
            if (state == ST_RUN) begin
                rsp_result[8*idx +: 8] <= alu_sum;
                z_acc                  <= z_acc & alu_z;
                idx                    <= last ? '0 : idx + 1'b1;
                // Sign and overflow come from the most-significant byte only;
                // zero must hold across every byte of the word.
                if (last) begin
                    rsp_n <= alu_n;
                    rsp_v <= alu_v;
                    rsp_z <= z_acc & alu_z;
                end
            end
        end
    end

    // ALU drive depends only on registered state so req_* never reaches alu_*.
    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_fn    = '0;
        alu_a     = '0;
        alu_b     = '0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                state_nx  = req_valid ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                alu_fn   = fn_q;
                alu_a    = a_q[8*idx +: 8];
                alu_b    = b_q[8*idx +: 8];
                state_nx = last ? ST_DONE : ST_RUN;
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                state_nx  = rsp_ready ? ST_IDLE : ST_DONE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule
